// File: rtl/fmac_seq_ctrl_pkg.sv
// Shared types and constants for the FloPoCo multiply-accumulate sequencer.
// A word is one FloPoCo float: {exception[1:0], sign, exponent[WE-1:0], fraction[WF-1:0]}.
package fmac_pkg;

   localparam int WE = 8;
   localparam int WF = 23;

   typedef logic [WE+WF+2:0] word_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      MUL_ISSUE,
      MUL_WAIT,
      ADD_ISSUE,
      ADD_WAIT,
      DONE
   } fmac_state_t;

   localparam logic [1:0] EXC_ZERO   = 2'b00;
   localparam logic [1:0] EXC_NORMAL = 2'b01;
   localparam logic [1:0] EXC_INF    = 2'b10;
   localparam logic [1:0] EXC_NAN    = 2'b11;

endpackage

// File: rtl/fmac_seq_ctrl_if.sv
// Operand-pair stream into the sequencer: valid/ready handshake plus the x/y words.
interface fmac_seq_ctrl_if #(
   parameter int W = 34
) ();

   logic         op_valid;
   logic         op_ready;
   logic [W-1:0] op_x;
   logic [W-1:0] op_y;

   modport master (output op_valid, output op_x, output op_y, input op_ready);
   modport slave  (input op_valid, input op_x, input op_y, output op_ready);

endinterface

// File: rtl/fmac_seq_ctrl_lat_timer.sv
// Loadable down-counter used to wait out the external pipeline latencies.
// expired is high while the count is zero; the count never wraps below zero.
module fmac_lat_timer #(
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          dec,
   output logic          expired
);

   logic [TW-1:0] cnt;

   // Load takes priority over decrement; saturate at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - TW'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/fmac_seq_ctrl.sv
// Dot-product sequencer: result = init_val + sum(x_i * y_i) over n_terms pairs,
// time-sharing one external FloPoCo fmul and one fadd. Words pass through untouched.
// Optional build macro FMAC_CE_EN adds fmul_ce/fadd_ce clock-enable outputs.
// With FMUL_LAT = 1 the product is forwarded straight from fmul_r in ADD_ISSUE,
// since that is the cycle in which the one-stage multiplier result is valid.
module fmac_seq_ctrl #(
   parameter int WE       = 8,
   parameter int WF       = 23,
   parameter int FMUL_LAT = 2,
   parameter int FADD_LAT = 3,
   parameter int CNT_W    = 8,
   localparam int W       = WE + WF + 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_terms,
   input  logic [W-1:0]     init_val,
   fmac_seq_ctrl_if.slave   op,
   output logic [W-1:0]     fmul_x,
   output logic [W-1:0]     fmul_y,
   input  logic [W-1:0]     fmul_r,
   output logic [W-1:0]     fadd_x,
   output logic [W-1:0]     fadd_y,
   input  logic [W-1:0]     fadd_r,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     result
`ifdef FMAC_CE_EN
   ,
   output logic             fmul_ce,
   output logic             fadd_ce
`endif
);

   import fmac_pkg::*;

   localparam int LAT_MAX = (FMUL_LAT > FADD_LAT) ? FMUL_LAT : FADD_LAT;
   localparam int TW      = $clog2(LAT_MAX) + 1;

   fmac_state_t      state, nstate;
   logic [W-1:0]     acc, prod, opx_q, opy_q, result_q;
   logic [CNT_W-1:0] remaining;
   logic             t_load, t_dec, t_expired;
   logic [TW-1:0]    t_val;

   fmac_lat_timer #(.TW(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .dec      (t_dec),
      .expired  (t_expired)
   );

   // State register; reset aborts any job and pending pipeline results are never captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   // Next-state logic and issue-slot outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch can be inferred.
      nstate      = state;
      op.op_ready = 1'b0;
      fmul_x      = '0;
      fmul_y      = '0;
      fadd_x      = '0;
      fadd_y      = '0;
      t_load      = 1'b0;
      t_dec       = 1'b0;
      t_val       = '0;
      case (state)
         IDLE:      if (start) nstate = (n_terms != '0) ? FETCH : DONE;
         FETCH: begin
            op.op_ready = 1'b1;
            if (op.op_valid) nstate = MUL_ISSUE;
         end
         MUL_ISSUE: begin
            fmul_x = opx_q;
            fmul_y = opy_q;
            t_load = 1'b1;
            t_val  = TW'(FMUL_LAT - 1);
            nstate = (FMUL_LAT == 1) ? ADD_ISSUE : MUL_WAIT;
         end
         MUL_WAIT: begin
            if (t_expired) nstate = ADD_ISSUE;
            else           t_dec  = 1'b1;
         end
         ADD_ISSUE: begin
            fadd_x = acc;
            fadd_y = (FMUL_LAT == 1) ? fmul_r : prod;
            t_load = 1'b1;
            t_val  = TW'(FADD_LAT - 1);
            nstate = ADD_WAIT;
         end
         ADD_WAIT: begin
            if (t_expired) nstate = (remaining == CNT_W'(1)) ? DONE : FETCH;
            else           t_dec  = 1'b1;
         end
         DONE:      nstate = IDLE;
         default:   nstate = IDLE;
      endcase
   end

   // Datapath registers: job setup, operand capture, product/accumulator capture, result.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: all datapath state is reset so outputs read zero right after an abort.
      if (rst) begin
         acc       <= '0;
         prod      <= '0;
         opx_q     <= '0;
         opy_q     <= '0;
         result_q  <= '0;
         remaining <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         case (state)
            IDLE: if (start) begin
               remaining <= n_terms;
               acc       <= init_val;
            end
            FETCH: if (op.op_valid) begin
               opx_q <= op.op_x;
               opy_q <= op.op_y;
            end
            MUL_WAIT:  if (t_expired) prod <= fmul_r;
            ADD_ISSUE: if (FMUL_LAT == 1) prod <= fmul_r;
            ADD_WAIT: if (t_expired) begin
               acc       <= fadd_r;
               remaining <= remaining - CNT_W'(1);
            end
            DONE:      result_q <= acc;
            default:   ;
         endcase
      end
   end

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign result = (state == DONE) ? acc : result_q;

`ifdef FMAC_CE_EN
   assign fmul_ce = (state == MUL_ISSUE) || (state == MUL_WAIT);
   assign fadd_ce = (state == ADD_ISSUE) || (state == ADD_WAIT);
`endif

endmodule

// File: tb/tb_fmac_seq_ctrl.sv
// Self-checking bench for fmac_seq_ctrl: behavioural FloPoCo fmul/fadd stand-ins,
// a per-job schedule model built from the cycle-count rules, and a per-cycle compare.
module tb_fmac_seq_ctrl;
   import fmac_pkg::*;

   localparam int FL    = 2;
   localparam int FA    = 3;
   localparam int CNT_W = 8;
   localparam int W     = WE + WF + 3;

   localparam word_t F14  = {EXC_NORMAL, 1'b0, 8'd130, 23'h600000};
   localparam word_t F5P5 = {EXC_NORMAL, 1'b0, 8'd129, 23'h300000};
   localparam word_t F5   = {EXC_NORMAL, 1'b0, 8'd129, 23'h200000};
   localparam word_t F255 = {EXC_NORMAL, 1'b0, 8'd134, 23'h7F0000};

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] n_terms;
   word_t            init_val;
   word_t            fmul_x, fmul_y, fmul_r, fadd_x, fadd_y, fadd_r, result;
   logic             busy, done;
`ifdef FMAC_CE_EN
   logic             fmul_ce, fadd_ce;
`endif

   fmac_seq_ctrl_if #(.W(W)) opif ();

   fmac_seq_ctrl #(.WE(WE), .WF(WF), .FMUL_LAT(FL), .FADD_LAT(FA), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .n_terms  (n_terms),
      .init_val (init_val),
      .op       (opif),
      .fmul_x   (fmul_x),
      .fmul_y   (fmul_y),
      .fmul_r   (fmul_r),
      .fadd_x   (fadd_x),
      .fadd_y   (fadd_y),
      .fadd_r   (fadd_r),
      .busy     (busy),
      .done     (done),
      .result   (result)
`ifdef FMAC_CE_EN
      ,
      .fmul_ce  (fmul_ce),
      .fadd_ce  (fadd_ce)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- FloPoCo word <-> real helpers ----------------
   function automatic word_t to_fp(real r);
      logic [63:0] b;
      int          e;
      if (r == 0.0) return '0;
      b = $realtobits(r);
      e = int'(b[62:52]) - 1023 + 127;
      return {EXC_NORMAL, b[63], e[7:0], b[51:29]};
   endfunction

   function automatic real from_fp(word_t w);
      logic [63:0] b;
      int          e;
      if (w[W-1:W-2] == EXC_ZERO) return 0.0;
      e = int'(w[WE+WF-1:WF]) + 1023 - 127;
      b = {w[WE+WF], e[10:0], w[WF-1:0], 29'b0};
      return $bitstoreal(b);
   endfunction

   // ---------------- external pipelined units ----------------
   word_t mpipe [FL];
   word_t apipe [FA];
   always @(posedge clk) begin
      mpipe[0] <= to_fp(from_fp(fmul_x) * from_fp(fmul_y));
      for (int i = 1; i < FL; i++) mpipe[i] <= mpipe[i-1];
      apipe[0] <= to_fp(from_fp(fadd_x) + from_fp(fadd_y));
      for (int i = 1; i < FA; i++) apipe[i] <= apipe[i-1];
   end
   assign fmul_r = mpipe[FL-1];
   assign fadd_r = apipe[FA-1];

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_err    = 0;

   task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- job model state ----------------
   bit    vpat [0:8191];
   real   tx [256];
   real   ty [256];
   word_t e_mx [int], e_my [int], e_ax [int], e_ay [int];
   bit    e_ready [int], e_mce [int], e_ace [int];
   int    job_t0, done_r;
   bit    job_active = 1'b0;
   bit    chk_en     = 1'b0;
   word_t exp_res, prev_res, hold_res;
   int    dut_done_r, ready_cnt;
   bit    nz_seen;

   // Per-cycle compare of every DUT output against the job schedule model.
   always @(negedge clk) begin : compare
      int  r;
      bit  in_job;
      if (chk_en) begin
         r      = cyc - job_t0;
         in_job = job_active && (r >= 0) && (r <= done_r);
         if (in_job) begin
            if (r == 0) begin
               dut_done_r = -1;
               ready_cnt  = 0;
               nz_seen    = 1'b0;
            end
            if (done && dut_done_r < 0) dut_done_r = r;
            if (opif.op_ready) ready_cnt++;
            if ((fmul_x | fmul_y | fadd_x | fadd_y) != '0) nz_seen = 1'b1;
            check("busy",     W'(busy),          W'(r >= 1));
            check("done",     W'(done),          W'(r == done_r));
            check("op_ready", W'(opif.op_ready), W'(e_ready.exists(r)));
            check("fmul_x",   fmul_x, e_mx.exists(r) ? e_mx[r] : '0);
            check("fmul_y",   fmul_y, e_my.exists(r) ? e_my[r] : '0);
            check("fadd_x",   fadd_x, e_ax.exists(r) ? e_ax[r] : '0);
            check("fadd_y",   fadd_y, e_ay.exists(r) ? e_ay[r] : '0);
            check("result",   result, (r == done_r) ? exp_res : prev_res);
`ifdef FMAC_CE_EN
            check("fmul_ce",  W'(fmul_ce), W'(e_mce.exists(r)));
            check("fadd_ce",  W'(fadd_ce), W'(e_ace.exists(r)));
`endif
         end else begin
            check("idle_busy",     W'(busy),          '0);
            check("idle_done",     W'(done),          '0);
            check("idle_op_ready", W'(opif.op_ready), '0);
            check("idle_fmul_x",   fmul_x,            '0);
            check("idle_fadd_y",   fadd_y,            '0);
            check("idle_result",   result,            hold_res);
`ifdef FMAC_CE_EN
            check("idle_fmul_ce",  W'(fmul_ce),       '0);
            check("idle_fadd_ce",  W'(fadd_ce),       '0);
`endif
         end
      end
   end

   task automatic outputs_zero(string tag);
      check({tag, "_busy"},     W'(busy),          '0);
      check({tag, "_done"},     W'(done),          '0);
      check({tag, "_op_ready"}, W'(opif.op_ready), '0);
      check({tag, "_fmul_x"},   fmul_x,            '0);
      check({tag, "_fmul_y"},   fmul_y,            '0);
      check({tag, "_fadd_x"},   fadd_x,            '0);
      check({tag, "_fadd_y"},   fadd_y,            '0);
      check({tag, "_result"},   result,            '0);
   endtask

   // Build the expected schedule for one job, then drive it. Entered #1 after an edge;
   // returns #1 after the edge following the done cycle (or after an abort).
   task automatic run_job(input int n, input real init, input int abort_r, input int ign_r);
      int  r, j;
      bit  hs;
      real acc;
      e_mx.delete(); e_my.delete(); e_ax.delete(); e_ay.delete();
      e_ready.delete(); e_mce.delete(); e_ace.delete();
      prev_res = hold_res;
      r   = 1;
      acc = init;
      for (int k = 0; k < n; k++) begin
         while (!vpat[r]) begin
            e_ready[r] = 1'b1;
            r++;
         end
         e_ready[r] = 1'b1;
         r++;
         e_mx[r] = to_fp(tx[k]);
         e_my[r] = to_fp(ty[k]);
         for (int i = 0; i <= FL; i++) e_mce[r+i] = 1'b1;
         r += 1 + FL;
         e_ax[r] = to_fp(acc);
         e_ay[r] = to_fp(tx[k] * ty[k]);
         for (int i = 0; i <= FA; i++) e_ace[r+i] = 1'b1;
         acc += tx[k] * ty[k];
         r += 1 + FA;
      end
      done_r  = r;
      exp_res = to_fp(acc);

      job_t0        = cyc;
      job_active    = 1'b1;
      start         = 1'b1;
      n_terms       = CNT_W'(n);
      init_val      = to_fp(init);
      opif.op_valid = 1'b0;
      j = 0;
      for (int c = 0; c <= done_r; c++) begin
         @(negedge clk);
         hs = opif.op_valid && opif.op_ready;
         @(posedge clk);
         #1;
         if (hs) j++;
         r     = cyc - job_t0;
         start = (r == ign_r);
         if (r == ign_r) begin
            n_terms  = CNT_W'(3);
            init_val = to_fp(99.0);
         end
         opif.op_valid = vpat[r] && (j < n);
         opif.op_x     = (j < n) ? to_fp(tx[j]) : '0;
         opif.op_y     = (j < n) ? to_fp(ty[j]) : '0;
         if (r == abort_r) begin
            chk_en     = 1'b0;
            job_active = 1'b0;
            #2;
            rst = 1'b1;
            #1;
            outputs_zero("abort");
            start         = 1'b0;
            opif.op_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst      = 1'b0;
            hold_res = '0;
            chk_en   = 1'b1;
            return;
         end
      end
      hold_res = exp_res;
   endtask

   task automatic vpat_fill(input int mode);
      for (int i = 0; i < 8192; i++)
         vpat[i] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      n_terms       = '0;
      init_val      = '0;
      opif.op_valid = 1'b0;
      opif.op_x     = '0;
      opif.op_y     = '0;
      hold_res      = '0;
      prev_res      = '0;
      repeat (3) @(posedge clk);
      #1;
      outputs_zero("reset");
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Two terms: 0 + 1*2 + 3*4 = 14, done 17 cycles after the start cycle.
      vpat_fill(0);
      tx[0] = 1.0; ty[0] = 2.0; tx[1] = 3.0; ty[1] = 4.0;
      run_job(2, 0.0, -1, -1);
      check("j1_done_latency", W'(dut_done_r), W'(17));
      check("j1_result",       result,         F14);
      check("j1_ready_cycles", W'(ready_cnt),  W'(2));

      // Zero terms, back-to-back start: init passes straight through.
      run_job(0, 5.5, -1, -1);
      check("j2_done_latency", W'(dut_done_r), W'(1));
      check("j2_result",       result,         F5P5);
      check("j2_no_operands",  W'(nz_seen),    '0);

      // Operand stream withheld for 10 FETCH cycles.
      vpat_fill(0);
      for (int i = 1; i <= 10; i++) vpat[i] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tx[k] = real'(int'($urandom_range(1, 9)));
         ty[k] = real'(int'($urandom_range(0, 16)) - 8);
      end
      run_job(3, 2.0, -1, -1);
      check("j3_done_latency", W'(dut_done_r), W'(35));
      check("j3_ready_cycles", W'(ready_cnt),  W'(13));

      // Async reset in ADD_WAIT of term 2 of 4, then a fresh one-term job.
      vpat_fill(0);
      for (int k = 0; k < 4; k++) begin tx[k] = 1.0; ty[k] = 1.0; end
      run_job(4, 1.0, 15, -1);
      repeat (2) @(posedge clk);
      #1;
      tx[0] = 2.0; ty[0] = 2.0;
      run_job(1, 1.0, -1, -1);
      check("j5_result", result, F5);

      // Maximum term count, with a stray start mid-job.
      for (int k = 0; k < 255; k++) begin tx[k] = 1.0; ty[k] = 1.0; end
      run_job(255, 0.0, -1, 5);
      check("j6_result",       result,         F255);
      check("j6_done_latency", W'(dut_done_r), W'(1 + 255 * (FL + FA + 3)));

      // Randomised back-to-back jobs with a bursty operand stream.
      for (int job = 0; job < 8; job++) begin
         int n;
         vpat_fill(1);
         n = int'($urandom_range(0, 6));
         for (int k = 0; k < n; k++) begin
            tx[k] = real'(int'($urandom_range(0, 16)) - 8);
            ty[k] = real'(int'($urandom_range(0, 16)) - 8);
         end
         run_job(n, real'(int'($urandom_range(0, 32)) - 16), -1, -1);
      end

      repeat (4) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
